// File: rtl/cfg_serial_rx_pkg.sv
// Shared constants, state encoding and helpers for the configuration serial
// receiver. Optional feature macro: CFG_SERIAL_RX_PARITY_EN (adds a trailing
// even-parity bit to every frame).
package cfg_serial_rx_pkg;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 10;
  localparam int FRAME_BITS = 15;
  localparam int CNT_W      = 5;

`ifdef CFG_SERIAL_RX_PARITY_EN
  localparam int SHIFT_W = FRAME_BITS + 1;
`else
  localparam int SHIFT_W = FRAME_BITS;
`endif

  // A frame is accepted only with exactly SHIFT_W bits; the counter saturates
  // one above that so over-long frames stay distinguishable.
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(SHIFT_W);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(SHIFT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam int ERR_LEN = 0;
  localparam int ERR_TMO = 1;
  localparam int ERR_PAR = 2;

  // Even parity holds when the XOR over all bits, parity bit included, is 0.
  function automatic logic even_parity_ok(input logic [SHIFT_W-1:0] bits);
    return ((^bits) == 1'b0);
  endfunction

endpackage

// File: rtl/cfg_rx_sync.sv
// Multi-flop synchroniser for one asynchronous pad input.
module cfg_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the pad value one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Synchroniser flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cfg_serial_rx.sv
// Configuration frame receiver: synchronises the 3-wire pad interface
// (sclk/sen/sdi), deserialises frames MSB first and emits addr/data with a
// one-cycle valid. Bad frames are dropped and flagged in sticky err bits.
// Optional feature macro: CFG_SERIAL_RX_PARITY_EN.
module cfg_serial_rx
  import cfg_serial_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        sen_i,
  input  logic        sdi_i,
  output logic        valid,
  output logic [4:0]  addr,
  output logic [9:0]  data,
  output logic [2:0]  err,
  input  logic        err_clr,
  output logic [7:0]  frame_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic sclk_s, sen_s, sdi_s;
  logic sclk_h_d, sclk_h_q, sen_h_d, sen_h_q;
  logic sclk_rise, sen_rise, sen_fall;

  // Marks when the synchronisers hold real pad values rather than reset zeros.
  logic [SYNC_STAGES-1:0] fill_d, fill_q;
  logic primed;
  // Set once sen has genuinely been seen low; a frame may only start when set.
  logic armed_d, armed_q;

  state_e              state_d, state_q;
  logic [SHIFT_W-1:0]  shift_d, shift_q, shift_nxt;
  logic [CNT_W-1:0]    cnt_d, cnt_q, cnt_nxt;
  logic [TMO_W-1:0]    tmo_d, tmo_q, tmo_inc;
  logic                valid_d, valid_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [DATA_W-1:0]   data_d, data_q;
  logic [2:0]          err_d, err_q, err_set;
  logic [7:0]          frame_cnt_d, frame_cnt_q;

  cfg_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk_i), .q_o(sclk_s));
  cfg_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sen (
    .clk(clk), .rst(rst), .d_i(sen_i), .q_o(sen_s));
  cfg_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst(rst), .d_i(sdi_i), .q_o(sdi_s));

  assign sclk_rise = sclk_s & ~sclk_h_q;
  assign sen_rise  = sen_s & ~sen_h_q;
  assign sen_fall  = ~sen_s & sen_h_q;
  assign primed    = fill_q[SYNC_STAGES-1];

  // Edge history, synchroniser fill tracking and frame-start arming.
  always_comb begin
    sclk_h_d = sclk_s;
    sen_h_d  = sen_s;
    fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
    if (primed && !sen_s) begin
      armed_d = 1'b1;
    end else if (state_q == IDLE && sen_rise) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // Receive FSM: next state, datapath updates and error events.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    valid_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    err_set     = 3'b000;
    tmo_inc     = tmo_q + TMO_W'(1);

    // A same-cycle sclk edge is absorbed before the frame is judged.
    if (sclk_rise) begin
      shift_nxt = {shift_q[SHIFT_W-2:0], sdi_s};
      cnt_nxt   = (cnt_q == CNT_SAT) ? CNT_SAT : (cnt_q + CNT_W'(1));
    end else begin
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (sen_rise && armed_q) begin
          state_d = SHIFT;
          shift_d = {SHIFT_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          tmo_d   = {TMO_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d = shift_nxt;
        cnt_d   = cnt_nxt;
        tmo_d   = sclk_rise ? {TMO_W{1'b0}} : tmo_inc;
        if (sen_fall) begin
          state_d = IDLE;
          if (cnt_nxt == CNT_ACCEPT) begin
`ifdef CFG_SERIAL_RX_PARITY_EN
            if (even_parity_ok(shift_nxt)) begin
              valid_d     = 1'b1;
              addr_d      = shift_nxt[SHIFT_W-1 -: ADDR_W];
              data_d      = shift_nxt[SHIFT_W-1-ADDR_W -: DATA_W];
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              err_set[ERR_PAR] = 1'b1;
            end
`else
            valid_d     = 1'b1;
            addr_d      = shift_nxt[SHIFT_W-1 -: ADDR_W];
            data_d      = shift_nxt[SHIFT_W-1-ADDR_W -: DATA_W];
            frame_cnt_d = frame_cnt_q + 8'd1;
`endif
          end else begin
            err_set[ERR_LEN] = 1'b1;
          end
        end else if (!sclk_rise && (tmo_inc == TMO_LAST)) begin
          err_set[ERR_TMO] = 1'b1;
          state_d          = ERR;
        end else begin
          state_d = SHIFT;
        end
      end
      ERR: begin
        if (!sen_s) begin
          state_d = IDLE;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky errors: a new event in the clearing cycle still lands.
    err_d = (err_clr ? 3'b000 : err_q) | err_set;
`ifndef CFG_SERIAL_RX_PARITY_EN
    err_d[ERR_PAR] = 1'b0;
`endif
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_h_q    <= 1'b0;
      sen_h_q     <= 1'b0;
      fill_q      <= {SYNC_STAGES{1'b0}};
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= {SHIFT_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
      valid_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      err_q       <= 3'b000;
      frame_cnt_q <= 8'd0;
    end else begin
      sclk_h_q    <= sclk_h_d;
      sen_h_q     <= sen_h_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign valid     = valid_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cfg_serial_rx.sv
// Self-checking bench for cfg_serial_rx: scoreboard of expected frames,
// checked whenever valid pulses.
module tb_cfg_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_i, sen_i, sdi_i, err_clr;
  logic       valid;
  logic [4:0] addr;
  logic [9:0] data;
  logic [2:0] err;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int vc0;
  logic       prev_valid = 1'b0;
  logic [22:0] exp_q[$];
  logic [22:0] mon_e;
  logic [7:0] exp_cnt = 8'd0;
  logic [4:0] last_addr = 5'd0;
  logic [9:0] last_data = 10'd0;

`ifdef CFG_SERIAL_RX_PARITY_EN
  localparam int FRAME_N = 16;
`else
  localparam int FRAME_N = 15;
`endif

  cfg_serial_rx dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .sen_i(sen_i), .sdi_i(sdi_i),
    .valid(valid), .addr(addr), .data(data), .err(err),
    .err_clr(err_clr), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n bits MSB first (bits[n-1] first) with sclk = clk/8.
  task automatic send_bits(input logic [16:0] bits, input int n, input bit keep_sen);
    sen_i = 1'b1;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdi_i = bits[i];
      tick(4);
      sclk_i = 1'b1;
      tick(4);
      sclk_i = 1'b0;
    end
    tick(4);
    if (!keep_sen) begin
      sen_i = 1'b0;
      tick(8);
    end
  endtask

  function automatic logic [16:0] mk_frame(input logic [4:0] a, input logic [9:0] d);
`ifdef CFG_SERIAL_RX_PARITY_EN
    return {1'b0, a, d, ^{a, d}};
`else
    return {2'b00, a, d};
`endif
  endfunction

  task automatic good_frame(input logic [4:0] a, input logic [9:0] d);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({a, d, exp_cnt});
    last_addr = a;
    last_data = d;
    send_bits(mk_frame(a, d), FRAME_N, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        valid_cnt++;
        check_eq("valid_single", 32'(prev_valid), 32'd0);
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("sb_addr", 32'(addr), 32'(mon_e[22:18]));
          check_eq("sb_data", 32'(data), 32'(mon_e[17:8]));
          check_eq("sb_cnt", 32'(frame_cnt), 32'(mon_e[7:0]));
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sclk_i = 1'b0; sen_i = 1'b0; sdi_i = 1'b0; err_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);

    // Single frame.
    vc0 = valid_cnt;
    good_frame(5'd3, 10'h001);
    drain("f1_drain");
    check_eq("f1_pulses", 32'(valid_cnt - vc0), 32'd1);
    check_eq("f1_err", 32'(err), 32'd0);
    check_eq("f1_fcnt", 32'(frame_cnt), 32'd1);

    // Back-to-back frames.
    vc0 = valid_cnt;
    good_frame(5'd0, 10'h0BC);
    good_frame(5'd22, 10'h03F);
    drain("b2b_drain");
    check_eq("b2b_pulses", 32'(valid_cnt - vc0), 32'd2);
    check_eq("b2b_fcnt", 32'(frame_cnt), 32'(exp_cnt));

    // Short and long frames are dropped.
    vc0 = valid_cnt;
    send_bits(17'h0ABCD, 14, 1'b0);
    send_bits(17'h1FFFF, FRAME_N + 1, 1'b0);
    check_eq("len_novalid", 32'(valid_cnt - vc0), 32'd0);
    check_eq("len_err", 32'(err), 32'd1);
    check_eq("len_addr", 32'(addr), 32'(last_addr));
    check_eq("len_data", 32'(data), 32'(last_data));
    pulse_clr();
    check_eq("len_clr", 32'(err), 32'd0);

    // Timeout, then ignored activity while sen stays high.
    vc0 = valid_cnt;
    send_bits(17'h00005, 3, 1'b1);
    tick(1100);
    check_eq("tmo_err", 32'(err), 32'd2);
    check_eq("tmo_state", 32'(dut.state_q), 32'd2);
    for (int i = 0; i < FRAME_N; i++) begin
      sdi_i = i[0];
      tick(4);
      sclk_i = 1'b1;
      tick(4);
      sclk_i = 1'b0;
    end
    tick(8);
    check_eq("tmo_ignore", 32'(valid_cnt - vc0), 32'd0);
    check_eq("tmo_hold", 32'(dut.state_q), 32'd2);
    sen_i = 1'b0;
    tick(8);
    good_frame(5'd9, 10'h155);
    drain("tmo_drain");
    check_eq("tmo_sticky", 32'(err), 32'd2);
    pulse_clr();

    // Reset mid-frame with sen held high.
    vc0 = valid_cnt;
    send_bits(mk_frame(5'd31, 10'h3FF), 7, 1'b1);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    exp_cnt = 8'd0;
    tick(2);
    check_eq("mrst_valid", 32'(valid), 32'd0);
    check_eq("mrst_addr", 32'(addr), 32'd0);
    check_eq("mrst_data", 32'(data), 32'd0);
    check_eq("mrst_fcnt", 32'(frame_cnt), 32'd0);
    tick(1100);
    check_eq("mrst_err", 32'(err), 32'd0);
    check_eq("mrst_novalid", 32'(valid_cnt - vc0), 32'd0);
    sen_i = 1'b0;
    tick(8);
    good_frame(5'd17, 10'h2A5);
    drain("mrst_drain");
    check_eq("mrst_fcnt1", 32'(frame_cnt), 32'd1);

`ifdef CFG_SERIAL_RX_PARITY_EN
    // Bad parity is flagged, good parity accepted.
    vc0 = valid_cnt;
    send_bits({1'b0, 5'd1, 10'h0C7, 1'b1}, 16, 1'b0);
    check_eq("par_err", 32'(err), 32'd4);
    check_eq("par_novalid", 32'(valid_cnt - vc0), 32'd0);
    good_frame(5'd1, 10'h0C7);
    drain("par_drain");
    check_eq("par_data", 32'(data), 32'h0C7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
